// File: rtl/vga_capture.sv
// Video input receiver for the parallel RGB/HSYNC/VSYNC/DE link.
// Registers the incoming link once and normalises the sync polarities.
// Measures the line and frame timing and tracks whether that timing is stable.
// Packs each active pixel into the VRAM word format and issues one write per pixel.
// Ports:
//   lcd_clk_i, rst_i (async, active-low)
//   capture_en_i                        arm / keep capturing frames
//   lcd_h_synk_i, lcd_v_synk_i, lcd_de_i, lcd_r_i/g_i/b_i   incoming video
//   vram_addr_o, vram_data_o, vram_we_o                     VRAM write port
//   h_pos_o, v_pos_o                    active column / line of the current write
//   h_total_o, h_res_o, v_total_o, v_res_o                  last measured timing
//   locked_o, frame_done_o              timing stable / end-of-captured-frame pulse
module vga_capture #(
  parameter bit          HSYNK_INVERTED_CONF       = 1'b0,
  parameter bit          VSYNK_INVERTED_CONF       = 1'b0,
  parameter bit          DATA_ENABLE_INVERTED_CONF = 1'b0,
  parameter int unsigned PIXEL_SIZE_CONF           = 24,
  parameter int unsigned BUS_VRAM_ADDR_LEN         = 24
) (
  input  logic                         lcd_clk_i,
  input  logic                         rst_i,
  input  logic                         capture_en_i,
  input  logic                         lcd_h_synk_i,
  input  logic                         lcd_v_synk_i,
  input  logic                         lcd_de_i,
  input  logic [7:0]                   lcd_r_i,
  input  logic [7:0]                   lcd_g_i,
  input  logic [7:0]                   lcd_b_i,
  output logic [BUS_VRAM_ADDR_LEN-1:0] vram_addr_o,
  output logic [31:0]                  vram_data_o,
  output logic                         vram_we_o,
  output logic [12:0]                  h_pos_o,
  output logic [12:0]                  v_pos_o,
  output logic [12:0]                  h_total_o,
  output logic [12:0]                  h_res_o,
  output logic [12:0]                  v_total_o,
  output logic [12:0]                  v_res_o,
  output logic                         locked_o,
  output logic                         frame_done_o
);

  localparam logic [12:0] CntMax = 13'h1fff;
  localparam logic [BUS_VRAM_ADDR_LEN-1:0] AddrOne = {{(BUS_VRAM_ADDR_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWaitVs, StCapture} state_e;

  function automatic logic [12:0] sat_inc(input logic [12:0] v);
    return (v == CntMax) ? v : v + 13'd1;
  endfunction

  // Input stage (S1), polarity-normalised.
  logic       en_q, hs_q, vs_q, de_q, hs_prev_q, vs_prev_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge lcd_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      r_q       <= 8'h0;
      g_q       <= 8'h0;
      b_q       <= 8'h0;
    end else begin
      en_q      <= capture_en_i;
      hs_q      <= lcd_h_synk_i ^ HSYNK_INVERTED_CONF;
      vs_q      <= lcd_v_synk_i ^ VSYNK_INVERTED_CONF;
      de_q      <= lcd_de_i ^ DATA_ENABLE_INVERTED_CONF;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      r_q       <= lcd_r_i;
      g_q       <= lcd_g_i;
      b_q       <= lcd_b_i;
    end
  end

  logic hs_edge, vs_edge;
  assign hs_edge = hs_q & ~hs_prev_q;
  assign vs_edge = vs_q & ~vs_prev_q;

  // Counters, measurements and lock tracking.
  logic [12:0] hc_q, hc_d, px_q, px_d, px_base, lc_q, lc_d, lc_base, al_q, al_d, al_base;
  logic [12:0] h_total_q, h_total_d, h_res_q, h_res_d, v_total_q, v_total_d, v_res_q, v_res_d;
  logic [51:0] snap_q, snap_d, meas_new;
  logic [1:0]  stable_q, stable_d;

  assign meas_new = {h_total_d, h_res_d, lc_q, al_q};

  always_comb begin
    hc_d      = hs_edge ? 13'd0 : sat_inc(hc_q);
    h_total_d = hs_edge ? sat_inc(hc_q) : h_total_q;
    h_res_d   = (hs_edge && px_q != 13'd0) ? px_q : h_res_q;
    px_base   = hs_edge ? 13'd0 : px_q;
    px_d      = de_q ? sat_inc(px_base) : px_base;
    // The hs edge that coincides with a vs edge starts line 0 and counts as the first line.
    lc_base   = vs_edge ? 13'd0 : lc_q;
    lc_d      = hs_edge ? sat_inc(lc_base) : lc_base;
    al_base   = vs_edge ? 13'd0 : al_q;
    al_d      = (de_q && px_base == 13'd0) ? sat_inc(al_base) : al_base;
    v_total_d = vs_edge ? lc_q : v_total_q;
    v_res_d   = vs_edge ? al_q : v_res_q;
    snap_d    = snap_q;
    stable_d  = stable_q;
    if (vs_edge) begin
      snap_d = meas_new;
      if (meas_new == snap_q && h_res_d != 13'd0 && al_q != 13'd0) begin
        stable_d = (stable_q == 2'd2) ? 2'd2 : stable_q + 2'd1;
      end else begin
        stable_d = 2'd0;
      end
    end
  end

  // Pixel packing.
  logic [31:0] pix;
  always_comb begin
    if (PIXEL_SIZE_CONF == 32'd8) begin
      pix = {24'h0, b_q[7:5], g_q[7:6], r_q[7:5]};
    end else if (PIXEL_SIZE_CONF == 32'd16) begin
      pix = {16'h0, b_q[7:3], g_q[7:2], r_q[7:3]};
    end else begin
      pix = {8'h0, b_q, g_q, r_q};
    end
  end

  // Capture FSM and write port.
  state_e                       state_q, state_d;
  logic [BUS_VRAM_ADDR_LEN-1:0] wr_addr_q, wr_addr_d, vram_addr_q, vram_addr_d;
  logic [31:0]                  data_q, data_d;
  logic [12:0]                  h_pos_q, h_pos_d, v_pos_q, v_pos_d;
  logic                         we_q, we_d, frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    vram_addr_d  = vram_addr_q;
    data_d       = data_q;
    h_pos_d      = h_pos_q;
    v_pos_d      = v_pos_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_edge) begin
          state_d   = StCapture;
          wr_addr_d = '0;
        end
      end
      StCapture: begin
        if (de_q) begin
          we_d        = 1'b1;
          vram_addr_d = wr_addr_q;
          wr_addr_d   = wr_addr_q + AddrOne;
          data_d      = pix;
          h_pos_d     = px_base;
          v_pos_d     = al_d - 13'd1;
        end
        if (vs_edge) begin
          frame_done_d = 1'b1;
          wr_addr_d    = '0;
          if (!en_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge lcd_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hc_q         <= 13'd0;
      px_q         <= 13'd0;
      lc_q         <= 13'd0;
      al_q         <= 13'd0;
      h_total_q    <= 13'd0;
      h_res_q      <= 13'd0;
      v_total_q    <= 13'd0;
      v_res_q      <= 13'd0;
      snap_q       <= '0;
      stable_q     <= 2'd0;
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      vram_addr_q  <= '0;
      data_q       <= 32'h0;
      h_pos_q      <= 13'd0;
      v_pos_q      <= 13'd0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      px_q         <= px_d;
      lc_q         <= lc_d;
      al_q         <= al_d;
      h_total_q    <= h_total_d;
      h_res_q      <= h_res_d;
      v_total_q    <= v_total_d;
      v_res_q      <= v_res_d;
      snap_q       <= snap_d;
      stable_q     <= stable_d;
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      vram_addr_q  <= vram_addr_d;
      data_q       <= data_d;
      h_pos_q      <= h_pos_d;
      v_pos_q      <= v_pos_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign vram_addr_o  = vram_addr_q;
  assign vram_data_o  = data_q;
  assign vram_we_o    = we_q;
  assign h_pos_o      = h_pos_q;
  assign v_pos_o      = v_pos_q;
  assign h_total_o    = h_total_q;
  assign h_res_o      = h_res_q;
  assign v_total_o    = v_total_q;
  assign v_res_o      = v_res_q;
  assign locked_o     = (stable_q == 2'd2);
  assign frame_done_o = frame_done_q;

endmodule
